config_load_ctrl: RTL and testbench
===================================

// Module: config_load_ctrl
// PURPOSE
//   Sequences configuration of NUM_BLOCKS config-latch blocks that share one config bus.
//   Accepts a word-serial bitstream over a valid/ready handshake and assembles one MEM_SIZE-bit frame per block.
//   Pulses that block's cen for exactly one cclk, then moves to the next block.
//   Sits between the chip-level config port and the per-SLICEL latch blocks.
// PARAMETERS
//   MEM_SIZE    16  bits per latch block (LUT size); must be a multiple of WORD_BITS
//   WORD_BITS   4   width of the incoming config word
//   NUM_BLOCKS  8   number of latch blocks sequenced; block index width = max(1,$clog2(NUM_BLOCKS))
//   (derived) WPF = MEM_SIZE/WORD_BITS words per frame
// PORTS
//   cclk        in   1           config clock; all state updates on posedge
//   rst         in   1           synchronous, active-high reset
//   start       in   1           begin a full load sequence; sampled only in IDLE or DONE
//   din         in   WORD_BITS   config word
//   din_valid   in   1           din holds a valid word
//   din_ready   out  1           controller accepts din this cycle
//   config_out  out  MEM_SIZE    shared frame bus to every block's config_in
//   cen         out  NUM_BLOCKS  one-hot load enable; bit i loads block i
//   busy        out  1           high in LOAD or COMMIT
//   done        out  1           high in DONE; all blocks loaded
// BEHAVIOUR
//   Reset: state=IDLE; din_ready=0, cen=0, config_out=0, busy=0, done=0; word_cnt=0, blk_idx=0.
//   States: IDLE, LOAD, COMMIT, DONE. All outputs are decoded from registers only; no comb path from inputs.
//   IDLE:
//     - start=1 -> LOAD, with word_cnt=0 and blk_idx=0.
//   LOAD:
//     - din_ready=1.
//     - Transfer occurs iff din_valid & din_ready at posedge.
//     - On transfer: frame <= {din, frame[MEM_SIZE-1:WORD_BITS]} and word_cnt++.
//     - The first word of a frame ends in bits [WORD_BITS-1:0].
//     - No transfer -> frame and word_cnt hold. Gaps in din_valid are allowed with no loss or duplication.
//     - Transfer with word_cnt==WPF-1 -> COMMIT, word_cnt=0, config_out<=final frame.
//   COMMIT (exactly 1 cycle):
//     - din_ready=0 and cen=1<<blk_idx; config_out is stable the whole cycle.
//     - blk_idx==NUM_BLOCKS-1 -> DONE; else blk_idx++ and -> LOAD.
//   DONE:
//     - done=1, busy=0, din_ready=0.
//     - start=1 -> LOAD with counters cleared and done dropping the next cycle; else stay.
//   config_out holds the last committed frame until the next COMMIT. It is not cleared in DONE.
//   start in LOAD or COMMIT is ignored.
//   Latency: minimum 1+WPF cycles from start to the first cen pulse, and (WPF+1) cycles per block.
//   done rises the cycle after the cen[NUM_BLOCKS-1] pulse.
//   Reset mid-operation:
//     - The next edge returns to IDLE and discards any partial frame.
//     - cen is never asserted for a partial frame, so already-loaded blocks keep their contents.
//   Exactly one cen bit is ever high, and only in COMMIT. cen==0 in every other state.
// TESTING (defaults: WPF=4, NUM_BLOCKS=8)
//   1. Assert rst for 2 cycles with random inputs -> all outputs 0 and din_ready=0; start ignored while rst=1.
//   2. Pulse start, then drive din_valid=1 continuously with words 1,2,3,4.
//      -> cen=8'h01 for exactly 1 cycle, 5 cycles after start; config_out=16'h4321 in that cycle.
//   3. Full load at continuous valid -> cen walks 01,02,...,80; done=1 exactly 41 cycles after start.
//   4. din_valid toggled 1,0,0,1 between words of block 2 -> config_out still 16'h4321 and cen=8'h04 once.
//   5. Assert rst after 2 words of block 3 -> no cen pulse; IDLE.
//      Next start reloads from block 0, and the first cen is 8'h01.
//   6. Pulse start during LOAD -> ignored, no restart.
//      start in DONE -> done falls the next cycle and a new sequence completes.

Source files
------------

// File: rtl/config_load_ctrl.sv
// Config load sequencer: assembles word-serial config frames and commits each
// one to its latch block with a single-cycle one-hot cen pulse.
module config_load_ctrl #(
  parameter int unsigned MEM_SIZE   = 16,
  parameter int unsigned WORD_BITS  = 4,
  parameter int unsigned NUM_BLOCKS = 8
) (
  input  logic                  cclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_BITS-1:0]  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [MEM_SIZE-1:0]   config_out,
  output logic [NUM_BLOCKS-1:0] cen,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned WPF   = MEM_SIZE / WORD_BITS;
  localparam int unsigned CNT_W = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPF - 1);
  localparam logic [IDX_W-1:0] LAST_BLK  = IDX_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    word_cnt;
  logic [IDX_W-1:0]    blk_idx;
  logic [MEM_SIZE-1:0] frame;
  logic [MEM_SIZE-1:0] next_frame;
  logic                xfer;

  // New words enter at the top, so the first word of a frame ends in the LSBs.
  always_comb begin
    next_frame = MEM_SIZE'({din, frame} >> WORD_BITS);
    xfer       = din_valid & din_ready;
  end

  // Sequencer with every output held in a register.
  always_ff @(posedge cclk) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      blk_idx    <= '0;
      frame      <= '0;
      din_ready  <= 1'b0;
      config_out <= '0;
      cen        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            word_cnt  <= '0;
            blk_idx   <= '0;
            din_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end

        LOAD: begin
          if (xfer) begin
            frame <= next_frame;
            if (word_cnt == LAST_WORD) begin
              state      <= COMMIT;
              word_cnt   <= '0;
              config_out <= next_frame;
              din_ready  <= 1'b0;
              cen        <= NUM_BLOCKS'(1) << blk_idx;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end

        COMMIT: begin
          cen <= '0;
          if (blk_idx == LAST_BLK) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= LOAD;
            blk_idx   <= blk_idx + IDX_W'(1);
            din_ready <= 1'b1;
          end
        end

        DONE: begin
          if (start) begin
            state     <= LOAD;
            word_cnt  <= '0;
            blk_idx   <= '0;
            din_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          din_ready <= 1'b0;
          cen       <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_load_ctrl.sv
// Scoreboard bench for config_load_ctrl: the driver predicts each committed
// frame and its cen pulse cycle, and a negedge monitor checks every cen pulse.
module tb_config_load_ctrl;

  localparam int unsigned MEM_SIZE   = 16;
  localparam int unsigned WORD_BITS  = 4;
  localparam int unsigned NUM_BLOCKS = 8;
  localparam int unsigned WPF        = MEM_SIZE / WORD_BITS;

  logic                  cclk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [WORD_BITS-1:0]  din;
  logic                  din_valid;
  logic                  din_ready;
  logic [MEM_SIZE-1:0]   config_out;
  logic [NUM_BLOCKS-1:0] cen;
  logic                  busy;
  logic                  done;

  config_load_ctrl #(
    .MEM_SIZE  (MEM_SIZE),
    .WORD_BITS (WORD_BITS),
    .NUM_BLOCKS(NUM_BLOCKS)
  ) dut (
    .cclk      (cclk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .config_out(config_out),
    .cen       (cen),
    .busy      (busy),
    .done      (done)
  );

  always #5 cclk = ~cclk;

  typedef struct {
    logic [NUM_BLOCKS-1:0] cen;
    logic [MEM_SIZE-1:0]   frame;
    int                    cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   errors   = 0;
  int   checks   = 0;
  int   cen0_cyc = -1;

  always @(posedge cclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every cen pulse must match the oldest predicted commit.
  always @(negedge cclk) begin
    if (rst === 1'b0 && cen !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cen: got cen=%0h with no commit expected (cycle %0d)", cen, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cen", 64'(cen), 64'(e.cen));
        check("config_out", 64'(config_out), 64'(e.frame));
        check("cen_cycle", 64'(cyc), 64'(e.cyc));
        check("ready_in_commit", 64'(din_ready), 64'(0));
        if (cen == NUM_BLOCKS'(1)) cen0_cyc = cyc;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(din_ready), 64'(0));
    check({tag, "_cen"}, 64'(cen), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
  endtask

  task automatic do_start(output int t0);
    start     = 1'b1;
    din_valid = 1'b0;
    t0        = cyc;
    @(negedge cclk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'(1));
    check("start_done_low", 64'(done), 64'(0));
    check("start_ready", 64'(din_ready), 64'(1));
  endtask

  // Offer one word after a gap; optionally predict the commit it completes.
  task automatic send_word(input logic [WORD_BITS-1:0] w, input int gap, input bit push,
                           input logic [NUM_BLOCKS-1:0] ecen, input logic [MEM_SIZE-1:0] eframe);
    int n;
    repeat (gap) begin
      din_valid = 1'b0;
      din       = WORD_BITS'($urandom);
      @(negedge cclk);
    end
    din       = w;
    din_valid = 1'b1;
    n         = 0;
    while (din_ready !== 1'b1 && n < 20) begin
      @(negedge cclk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: din_ready stayed %b, required 1", din_ready);
    end else begin
      if (push) exp_q.push_back('{cen: ecen, frame: eframe, cyc: cyc + 1});
    end
    @(negedge cclk);
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge cclk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done=%b, required 1", done);
    end
    dc = cyc;
  endtask

  // One load sequence. gapmode: 0 continuous, 1 random gaps, 2 two-cycle gaps in block 2.
  task automatic run_seq(input bit fixed, input int gapmode, input int start_in_blk,
                         input bit timed, input int abort_blk);
    int                    t0;
    int                    dc;
    int                    gap;
    logic [WORD_BITS-1:0]  w[WPF];
    logic [MEM_SIZE-1:0]   frame;
    do_start(t0);
    cen0_cyc = -1;
    frame    = '0;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      frame = '0;
      for (int k = 0; k < WPF; k++) begin
        w[k]  = fixed ? WORD_BITS'(k + 1) : WORD_BITS'($urandom);
        frame = frame | (MEM_SIZE'(w[k]) << (WORD_BITS * k));
      end
      for (int k = 0; k < WPF; k++) begin
        if (b == abort_blk && k == 2) begin
          din_valid = 1'b0;
          rst       = 1'b1;
          @(negedge cclk);
          check_all_zero("abort");
          check("abort_config_out", 64'(config_out), 64'(0));
          rst = 1'b0;
          repeat (6) begin
            din_valid = 1'($urandom);
            din       = WORD_BITS'($urandom);
            @(negedge cclk);
          end
          din_valid = 1'b0;
          check_all_zero("post_abort_idle");
          return;
        end
        case (gapmode)
          1:       gap = int'($urandom_range(0, 2));
          2:       gap = (b == 2 && k > 0) ? 2 : 0;
          default: gap = 0;
        endcase
        if (b == start_in_blk && k == 0) start = 1'b1;
        send_word(w[k], gap, (k == WPF - 1) && (b != abort_blk),
                  NUM_BLOCKS'(1) << b, frame);
        start = 1'b0;
      end
    end
    din_valid = 1'b0;
    wait_done(dc);
    check("done_busy", 64'(busy), 64'(0));
    check("done_ready", 64'(din_ready), 64'(0));
    check("done_cen", 64'(cen), 64'(0));
    check("done_config_out", 64'(config_out), 64'(frame));
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    if (timed) begin
      check("first_cen_latency", 64'(cen0_cyc - t0), 64'(1 + WPF));
      check("done_latency", 64'(dc - t0), 64'(NUM_BLOCKS * (WPF + 1) + 1));
    end
    repeat (2) @(negedge cclk);
    check("done_holds", 64'(done), 64'(1));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'($urandom);
    din       = WORD_BITS'($urandom);
    din_valid = 1'($urandom);
    @(negedge cclk);
    start     = 1'($urandom);
    din       = WORD_BITS'($urandom);
    din_valid = 1'($urandom);
    @(negedge cclk);
    check_all_zero("reset");
    check("reset_config_out", 64'(config_out), 64'(0));
    rst       = 1'b0;
    start     = 1'b0;
    din_valid = 1'b0;
    @(negedge cclk);
    check_all_zero("idle_after_reset");

    run_seq(1'b1, 0, -1, 1'b1, -1);   // words 1,2,3,4 at continuous valid
    run_seq(1'b1, 2, -1, 1'b0, -1);   // valid gaps inside block 2
    run_seq(1'b0, 1, -1, 1'b0, -1);   // random words and gaps
    run_seq(1'b0, 1, -1, 1'b0, -1);
    run_seq(1'b0, 0, -1, 1'b0, 3);    // reset after two words of block 3
    run_seq(1'b0, 0, -1, 1'b1, -1);   // restart from IDLE begins at block 0
    run_seq(1'b0, 0, 1, 1'b1, -1);    // start during LOAD/COMMIT is ignored
    run_seq(1'b0, 0, -1, 1'b1, -1);   // restart from DONE

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
